// File: rtl/udp_echo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | udp_echo_pkg                                                          |
// | Shared state encoding and header constants for the UDP echo endpoint. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package udp_echo_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    RECV        = 2'd1,
    HDR_OUT     = 2'd2,
    PAYLOAD_OUT = 2'd3
  } echo_state_t;

  localparam int UDP_HDR_BYTES = 8;

  localparam logic [5:0]  c_default_dscp     = 6'd0;
  localparam logic [1:0]  c_default_ecn      = 2'd0;
  localparam logic [15:0] c_default_checksum = 16'd0;

endpackage
`default_nettype wire

// File: rtl/udp_payload_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | udp_payload_buffer                                                    |
// | Simple dual-port byte RAM with a registered, enable-gated read port.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module udp_payload_buffer #(
  parameter int DEPTH = 1472,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Read data only moves on rd_en so the consumer can stall without losing it.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/udp_echo_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | udp_echo_responder                                                    |
// | Store-and-forward UDP echo: buffers a datagram, returns it swapped.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module udp_echo_responder
  import udp_echo_pkg::*;
#(
  parameter int          MAX_PAYLOAD_BYTES = 1472,
  parameter logic [15:0] LISTEN_PORT       = 16'd5000,
  parameter logic [7:0]  TX_TTL            = 8'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_udp_hdr_valid,
  output logic        s_udp_hdr_ready,
  input  logic [31:0] s_udp_ip_source_ip,
  input  logic [31:0] s_udp_ip_dest_ip,
  input  logic [15:0] s_udp_source_port,
  input  logic [15:0] s_udp_dest_port,
  input  logic [7:0]  s_udp_payload_axis_tdata,
  input  logic        s_udp_payload_axis_tvalid,
  output logic        s_udp_payload_axis_tready,
  input  logic        s_udp_payload_axis_tlast,
  input  logic        s_udp_payload_axis_tuser,
  output logic        m_udp_hdr_valid,
  input  logic        m_udp_hdr_ready,
  output logic [5:0]  m_udp_ip_dscp,
  output logic [1:0]  m_udp_ip_ecn,
  output logic [7:0]  m_udp_ip_ttl,
  output logic [31:0] m_udp_ip_source_ip,
  output logic [31:0] m_udp_ip_dest_ip,
  output logic [15:0] m_udp_source_port,
  output logic [15:0] m_udp_dest_port,
  output logic [15:0] m_udp_length,
  output logic [15:0] m_udp_checksum,
  output logic [7:0]  m_udp_payload_axis_tdata,
  output logic        m_udp_payload_axis_tvalid,
  input  logic        m_udp_payload_axis_tready,
  output logic        m_udp_payload_axis_tlast,
  output logic        m_udp_payload_axis_tuser,
  output logic [15:0] frames_echoed,
  output logic [15:0] frames_dropped
);

  localparam int CNT_W = $clog2(MAX_PAYLOAD_BYTES + 1);
  localparam int AW    = $clog2(MAX_PAYLOAD_BYTES);
  localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_PAYLOAD_BYTES);

  echo_state_t r_state, w_next_state;

  logic [31:0]      r_rx_src_ip, r_rx_dst_ip;
  logic [15:0]      r_rx_src_port, r_rx_dst_port;
  logic [CNT_W-1:0] r_byte_count, w_count_next;
  logic             r_drop, r_overflow;
  logic [15:0]      r_length;
  logic             r_hdr_valid;
  logic [CNT_W-1:0] r_rd_addr, r_out_idx;
  logic [7:0]       r_tdata;
  logic             r_tvalid, r_tlast;
  logic [15:0]      r_frames_echoed, r_frames_dropped;

  logic       w_hdr_in_fire, w_beat, w_room, w_wr_en, w_ovf_now, w_bad;
  logic       w_hdr_out_fire, w_pl_fire, w_rd_en;
  logic [7:0] w_rd_data;

  assign w_hdr_in_fire  = (r_state == IDLE) && s_udp_hdr_valid;
  assign w_beat         = (r_state == RECV) && s_udp_payload_axis_tvalid;
  assign w_room         = (r_byte_count < c_max_cnt);
  assign w_wr_en        = w_beat && !r_drop && w_room;
  assign w_ovf_now      = r_overflow || (w_beat && !r_drop && !w_room);
  assign w_bad          = r_drop || w_ovf_now || s_udp_payload_axis_tuser;
  assign w_count_next   = w_room ? (r_byte_count + CNT_W'(1)) : r_byte_count;
  assign w_hdr_out_fire = (r_state == HDR_OUT) && r_hdr_valid && m_udp_hdr_ready;
  assign w_pl_fire      = (r_state == PAYLOAD_OUT) && r_tvalid && m_udp_payload_axis_tready;

  // One read on HDR_OUT entry primes byte 0; every later handshake refills the prefetch.
  assign w_rd_en = (((r_state == HDR_OUT) && !r_hdr_valid) || w_hdr_out_fire || w_pl_fire)
                   && (r_rd_addr < r_byte_count);

  udp_payload_buffer #(
    .DEPTH (MAX_PAYLOAD_BYTES),
    .WIDTH (8),
    .AW    (AW)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_addr (AW'(r_byte_count)),
    .wr_data (s_udp_payload_axis_tdata),
    .rd_en   (w_rd_en),
    .rd_addr (AW'(r_rd_addr)),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state              = r_state;
    s_udp_hdr_ready           = 1'b0;
    s_udp_payload_axis_tready = 1'b0;
    case (r_state)
      IDLE: begin
        s_udp_hdr_ready = 1'b1;
        if (s_udp_hdr_valid) w_next_state = RECV;
      end
      RECV: begin
        s_udp_payload_axis_tready = 1'b1;
        if (w_beat && s_udp_payload_axis_tlast) w_next_state = w_bad ? IDLE : HDR_OUT;
      end
      HDR_OUT: begin
        if (w_hdr_out_fire) w_next_state = PAYLOAD_OUT;
      end
      PAYLOAD_OUT: begin
        if (w_pl_fire && r_tlast) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_src_ip      <= '0;
      r_rx_dst_ip      <= '0;
      r_rx_src_port    <= '0;
      r_rx_dst_port    <= '0;
      r_byte_count     <= '0;
      r_drop           <= 1'b0;
      r_overflow       <= 1'b0;
      r_length         <= '0;
      r_hdr_valid      <= 1'b0;
      r_rd_addr        <= '0;
      r_out_idx        <= '0;
      r_tdata          <= '0;
      r_tvalid         <= 1'b0;
      r_tlast          <= 1'b0;
      r_frames_echoed  <= '0;
      r_frames_dropped <= '0;
    end else begin
      if (w_hdr_in_fire) begin
        r_rx_src_ip   <= s_udp_ip_source_ip;
        r_rx_dst_ip   <= s_udp_ip_dest_ip;
        r_rx_src_port <= s_udp_source_port;
        r_rx_dst_port <= s_udp_dest_port;
        r_byte_count  <= '0;
        r_overflow    <= 1'b0;
        r_drop        <= (s_udp_dest_port != LISTEN_PORT);
      end
      if (w_beat) begin
        r_byte_count <= w_count_next;
        r_overflow   <= w_ovf_now;
        if (s_udp_payload_axis_tlast) begin
          if (w_bad) begin
            r_frames_dropped <= r_frames_dropped + 16'd1;
          end else begin
            r_length  <= 16'(w_count_next) + 16'(UDP_HDR_BYTES);
            r_rd_addr <= '0;
          end
        end
      end
      if ((r_state == HDR_OUT) && !r_hdr_valid) r_hdr_valid <= 1'b1;
      if (w_rd_en) r_rd_addr <= r_rd_addr + CNT_W'(1);
      if (w_hdr_out_fire) begin
        r_hdr_valid <= 1'b0;
        r_tvalid    <= 1'b1;
        r_tdata     <= w_rd_data;
        r_tlast     <= (r_byte_count == CNT_W'(1));
        r_out_idx   <= '0;
      end
      if (w_pl_fire) begin
        if (r_tlast) begin
          r_tvalid        <= 1'b0;
          r_tlast         <= 1'b0;
          r_frames_echoed <= r_frames_echoed + 16'd1;
        end else begin
          r_tdata   <= w_rd_data;
          r_out_idx <= r_out_idx + CNT_W'(1);
          r_tlast   <= ((r_out_idx + CNT_W'(2)) == r_byte_count);
        end
      end
    end
  end

  // Reply goes back to the sender: local and remote endpoints swap roles.
  assign m_udp_hdr_valid           = r_hdr_valid;
  assign m_udp_ip_dscp             = c_default_dscp;
  assign m_udp_ip_ecn              = c_default_ecn;
  assign m_udp_ip_ttl              = TX_TTL;
  assign m_udp_ip_source_ip        = r_rx_dst_ip;
  assign m_udp_ip_dest_ip          = r_rx_src_ip;
  assign m_udp_source_port         = r_rx_dst_port;
  assign m_udp_dest_port           = r_rx_src_port;
  assign m_udp_length              = r_length;
  assign m_udp_checksum            = c_default_checksum;
  assign m_udp_payload_axis_tdata  = r_tdata;
  assign m_udp_payload_axis_tvalid = r_tvalid;
  assign m_udp_payload_axis_tlast  = r_tlast;
  assign m_udp_payload_axis_tuser  = 1'b0;
  assign frames_echoed             = r_frames_echoed;
  assign frames_dropped            = r_frames_dropped;

endmodule
`default_nettype wire

// File: tb/tb_udp_echo_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_udp_echo_responder                                                 |
// | Vector-table stimulus with a header/byte scoreboard for the echo.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_udp_echo_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_udp_hdr_valid, s_udp_hdr_ready;
  logic [31:0] s_udp_ip_source_ip, s_udp_ip_dest_ip;
  logic [15:0] s_udp_source_port, s_udp_dest_port;
  logic [7:0]  s_udp_payload_axis_tdata;
  logic        s_udp_payload_axis_tvalid, s_udp_payload_axis_tready;
  logic        s_udp_payload_axis_tlast, s_udp_payload_axis_tuser;
  logic        m_udp_hdr_valid, m_udp_hdr_ready;
  logic [5:0]  m_udp_ip_dscp;
  logic [1:0]  m_udp_ip_ecn;
  logic [7:0]  m_udp_ip_ttl;
  logic [31:0] m_udp_ip_source_ip, m_udp_ip_dest_ip;
  logic [15:0] m_udp_source_port, m_udp_dest_port, m_udp_length, m_udp_checksum;
  logic [7:0]  m_udp_payload_axis_tdata;
  logic        m_udp_payload_axis_tvalid, m_udp_payload_axis_tready;
  logic        m_udp_payload_axis_tlast, m_udp_payload_axis_tuser;
  logic [15:0] frames_echoed, frames_dropped;

  udp_echo_responder #(
    .MAX_PAYLOAD_BYTES (1472),
    .LISTEN_PORT       (16'd5000),
    .TX_TTL            (8'd64)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .s_udp_hdr_valid           (s_udp_hdr_valid),
    .s_udp_hdr_ready           (s_udp_hdr_ready),
    .s_udp_ip_source_ip        (s_udp_ip_source_ip),
    .s_udp_ip_dest_ip          (s_udp_ip_dest_ip),
    .s_udp_source_port         (s_udp_source_port),
    .s_udp_dest_port           (s_udp_dest_port),
    .s_udp_payload_axis_tdata  (s_udp_payload_axis_tdata),
    .s_udp_payload_axis_tvalid (s_udp_payload_axis_tvalid),
    .s_udp_payload_axis_tready (s_udp_payload_axis_tready),
    .s_udp_payload_axis_tlast  (s_udp_payload_axis_tlast),
    .s_udp_payload_axis_tuser  (s_udp_payload_axis_tuser),
    .m_udp_hdr_valid           (m_udp_hdr_valid),
    .m_udp_hdr_ready           (m_udp_hdr_ready),
    .m_udp_ip_dscp             (m_udp_ip_dscp),
    .m_udp_ip_ecn              (m_udp_ip_ecn),
    .m_udp_ip_ttl              (m_udp_ip_ttl),
    .m_udp_ip_source_ip        (m_udp_ip_source_ip),
    .m_udp_ip_dest_ip          (m_udp_ip_dest_ip),
    .m_udp_source_port         (m_udp_source_port),
    .m_udp_dest_port           (m_udp_dest_port),
    .m_udp_length              (m_udp_length),
    .m_udp_checksum            (m_udp_checksum),
    .m_udp_payload_axis_tdata  (m_udp_payload_axis_tdata),
    .m_udp_payload_axis_tvalid (m_udp_payload_axis_tvalid),
    .m_udp_payload_axis_tready (m_udp_payload_axis_tready),
    .m_udp_payload_axis_tlast  (m_udp_payload_axis_tlast),
    .m_udp_payload_axis_tuser  (m_udp_payload_axis_tuser),
    .frames_echoed             (frames_echoed),
    .frames_dropped            (frames_dropped)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] c_peer_ip  = 32'h0A000002;
  localparam logic [31:0] c_local_ip = 32'h0A000001;
  localparam logic [15:0] c_peer_port = 16'd1234;
  localparam int c_bound = 20000;

  typedef struct {
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [15:0] len;
  } hdr_t;

  typedef struct {
    logic [15:0] dport;
    int          len;
    logic [7:0]  seed;
    logic        err;
    logic        toggle;
    logic        exp_echo;
    logic [15:0] exp_echoed;
    logic [15:0] exp_dropped;
  } vec_t;

  hdr_t       hq[$];
  logic [8:0] bq[$];
  int tests = 0;
  int fails = 0;
  int beats_seen = 0;
  logic sink_toggle = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  // Drives one datagram; scoreboard entries are queued before the first beat.
  task automatic send_frame(input logic [15:0] dport, input int len, input logic [7:0] seed,
                            input logic err, input logic expect_echo);
    hdr_t h;
    logic ok;
    int n;
    if (expect_echo) begin
      h.sip = c_local_ip; h.dip = c_peer_ip; h.sp = dport; h.dp = c_peer_port;
      h.len = 16'(len + 8);
      hq.push_back(h);
      for (int i = 0; i < len; i++) bq.push_back({(i == len - 1), 8'(seed + 8'(i))});
    end
    @(posedge clk); #1;
    s_udp_hdr_valid = 1'b1;
    s_udp_ip_source_ip = c_peer_ip;
    s_udp_ip_dest_ip = c_local_ip;
    s_udp_source_port = c_peer_port;
    s_udp_dest_port = dport;
    n = 0;
    forever begin
      ok = s_udp_hdr_ready;
      @(posedge clk); #1;
      if (ok) break;
      n++;
      if (n > c_bound) begin timeout_fail("hdr_accept"); s_udp_hdr_valid = 1'b0; return; end
    end
    s_udp_hdr_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      s_udp_payload_axis_tvalid = 1'b1;
      s_udp_payload_axis_tdata = 8'(seed + 8'(i));
      s_udp_payload_axis_tlast = (i == len - 1);
      s_udp_payload_axis_tuser = (i == len - 1) ? err : 1'b0;
      n = 0;
      forever begin
        ok = s_udp_payload_axis_tready;
        @(posedge clk); #1;
        if (ok) break;
        n++;
        if (n > c_bound) begin timeout_fail("beat_accept"); s_udp_payload_axis_tvalid = 1'b0; return; end
      end
    end
    s_udp_payload_axis_tvalid = 1'b0;
    s_udp_payload_axis_tlast = 1'b0;
    s_udp_payload_axis_tuser = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((hq.size() != 0 || bq.size() != 0 || !s_udp_hdr_ready) && n < c_bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= c_bound) timeout_fail("drain");
  endtask

  // Echo sink readiness; toggle mode flips both readies every cycle.
  initial begin
    m_udp_hdr_ready = 1'b1;
    m_udp_payload_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (sink_toggle) begin
        m_udp_hdr_ready = ~m_udp_hdr_ready;
        m_udp_payload_axis_tready = ~m_udp_payload_axis_tready;
      end else begin
        m_udp_hdr_ready = 1'b1;
        m_udp_payload_axis_tready = 1'b1;
      end
    end
  end

  // Output monitor: scoreboard pops, stall stability and input backpressure.
  initial begin
    logic prev_v, prev_r, prev_l;
    logic [7:0] prev_d;
    hdr_t h;
    logic [8:0] eb;
    prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0; prev_d = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
        continue;
      end
      if (m_udp_hdr_valid || m_udp_payload_axis_tvalid)
        chk("in_ready_low", {s_udp_payload_axis_tready, s_udp_hdr_ready}, 0);
      if (m_udp_hdr_valid && m_udp_hdr_ready) begin
        if (hq.size() == 0) begin
          timeout_fail("unexpected_hdr");
        end else begin
          h = hq.pop_front();
          chk("hdr_ips", {m_udp_ip_source_ip, m_udp_ip_dest_ip}, {h.sip, h.dip});
          chk("hdr_ports", {m_udp_source_port, m_udp_dest_port}, {h.sp, h.dp});
          chk("hdr_length", m_udp_length, h.len);
          chk("hdr_consts", {m_udp_ip_dscp, m_udp_ip_ecn, m_udp_ip_ttl, m_udp_checksum},
              {6'd0, 2'd0, 8'd64, 16'd0});
        end
      end
      if (prev_v && !prev_r)
        chk("stall_hold", {m_udp_payload_axis_tvalid, m_udp_payload_axis_tlast, m_udp_payload_axis_tdata},
            {1'b1, prev_l, prev_d});
      if (m_udp_payload_axis_tvalid && m_udp_payload_axis_tready) begin
        beats_seen++;
        if (bq.size() == 0) begin
          timeout_fail("unexpected_byte");
        end else begin
          eb = bq.pop_front();
          chk("echo_byte", {m_udp_payload_axis_tuser, m_udp_payload_axis_tlast, m_udp_payload_axis_tdata},
              {1'b0, eb});
        end
      end
      prev_v = m_udp_payload_axis_tvalid;
      prev_r = m_udp_payload_axis_tready;
      prev_l = m_udp_payload_axis_tlast;
      prev_d = m_udp_payload_axis_tdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int base;
    int n;
    vecs[0] = '{16'd5000, 4,    8'h01, 1'b0, 1'b0, 1'b1, 16'd1, 16'd0};
    vecs[1] = '{16'd5001, 4,    8'h01, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1};
    vecs[2] = '{16'd5000, 1,    8'hAA, 1'b1, 1'b0, 1'b0, 16'd1, 16'd2};
    vecs[3] = '{16'd5000, 1,    8'h55, 1'b0, 1'b0, 1'b1, 16'd2, 16'd2};
    vecs[4] = '{16'd5000, 1473, 8'h10, 1'b0, 1'b0, 1'b0, 16'd2, 16'd3};
    vecs[5] = '{16'd5000, 1472, 8'h80, 1'b0, 1'b0, 1'b1, 16'd3, 16'd3};
    vecs[6] = '{16'd5000, 6,    8'hC0, 1'b0, 1'b1, 1'b1, 16'd4, 16'd3};

    rst_n = 1'b0;
    s_udp_hdr_valid = 1'b0;
    s_udp_ip_source_ip = '0;
    s_udp_ip_dest_ip = '0;
    s_udp_source_port = '0;
    s_udp_dest_port = '0;
    s_udp_payload_axis_tdata = '0;
    s_udp_payload_axis_tvalid = 1'b0;
    s_udp_payload_axis_tlast = 1'b0;
    s_udp_payload_axis_tuser = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {m_udp_hdr_valid, m_udp_payload_axis_tvalid, m_udp_payload_axis_tlast,
        m_udp_payload_axis_tdata, frames_echoed, frames_dropped, m_udp_length,
        s_udp_payload_axis_tready}, 0);
    chk("rst_ttl", m_udp_ip_ttl, 8'd64);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 7; v++) begin
      sink_toggle = vecs[v].toggle;
      send_frame(vecs[v].dport, vecs[v].len, vecs[v].seed, vecs[v].err, vecs[v].exp_echo);
      if (vecs[v].exp_echo) begin
        chk("lat_hdr_early", m_udp_hdr_valid, 1'b0);
        @(posedge clk); #1;
        chk("lat_hdr_on", m_udp_hdr_valid, 1'b1);
      end
      drain();
      chk("cnt_echoed", frames_echoed, vecs[v].exp_echoed);
      chk("cnt_dropped", frames_dropped, vecs[v].exp_dropped);
    end
    sink_toggle = 1'b0;
    repeat (2) @(posedge clk);

    // Asynchronous reset while the third echoed byte is on the bus.
    base = beats_seen;
    send_frame(16'd5000, 6, 8'h20, 1'b0, 1'b1);
    n = 0;
    while (beats_seen < base + 2 && n < c_bound) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= c_bound) timeout_fail("mid_echo_wait");
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {m_udp_hdr_valid, m_udp_payload_axis_tvalid, m_udp_payload_axis_tlast,
        m_udp_payload_axis_tdata, frames_echoed, frames_dropped, m_udp_length,
        m_udp_ip_source_ip, m_udp_dest_port}, 0);
    chk("midrst_ttl", m_udp_ip_ttl, 8'd64);
    hq.delete();
    bq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(16'd5000, 3, 8'h30, 1'b0, 1'b1);
    drain();
    chk("post_rst_echoed", frames_echoed, 16'd1);
    chk("post_rst_dropped", frames_dropped, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/udp_echo_responder.md
Name: udp_echo_responder

Overview:
Store-and-forward UDP echo endpoint that sits on the application side of the UDP stack. It consumes received UDP datagrams from the stack's UDP output (header plus 8-bit AXI-stream payload) and buffers the whole payload. For datagrams addressed to LISTEN_PORT that arrive without error, it returns the payload to the sender through the stack's UDP input with IPs and ports swapped. Errored, oversized and non-matching datagrams are drained and counted.

Parameters:
MAX_PAYLOAD_BYTES, 1472, payload buffer depth in bytes; larger datagrams are dropped.
LISTEN_PORT, 16'd5000, UDP destination port that is echoed.
TX_TTL, 8'd64, IP TTL on echoed datagrams.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
s_udp_hdr_valid  in  1  received header valid
s_udp_hdr_ready  out  1  received header accepted
s_udp_ip_source_ip  in  32  sender IP
s_udp_ip_dest_ip  in  32  local IP the datagram was sent to
s_udp_source_port  in  16  sender port
s_udp_dest_port  in  16  destination port
s_udp_payload_axis_tdata  in  8  received payload byte
s_udp_payload_axis_tvalid  in  1  payload valid
s_udp_payload_axis_tready  out  1  payload ready
s_udp_payload_axis_tlast  in  1  last payload byte
s_udp_payload_axis_tuser  in  1  frame error, sampled on tlast
m_udp_hdr_valid  out  1  echo header valid
m_udp_hdr_ready  in  1  echo header accepted
m_udp_ip_dscp  out  6  constant 0
m_udp_ip_ecn  out  2  constant 0
m_udp_ip_ttl  out  8  TX_TTL
m_udp_ip_source_ip  out  32  captured s_udp_ip_dest_ip
m_udp_ip_dest_ip  out  32  captured s_udp_ip_source_ip
m_udp_source_port  out  16  captured s_udp_dest_port
m_udp_dest_port  out  16  captured s_udp_source_port
m_udp_length  out  16  byte_count + 8
m_udp_checksum  out  16  constant 0 (checksum disabled)
m_udp_payload_axis_tdata  out  8  echoed byte
m_udp_payload_axis_tvalid  out  1  echoed byte valid
m_udp_payload_axis_tready  in  1  downstream ready
m_udp_payload_axis_tlast  out  1  last echoed byte
m_udp_payload_axis_tuser  out  1  constant 0
frames_echoed  out  16  count of completed echoes, wraps
frames_dropped  out  16  count of dropped datagrams, wraps

Behaviour:
- Reset (asynchronous on rst_n low): state IDLE. Every output, address field, counter, byte count and flag goes to 0. m_udp_ip_ttl still drives TX_TTL. A partially received or partially echoed frame is discarded. The frame is not counted.
- States:
  - IDLE: s_udp_hdr_ready=1. On header handshake, capture the IPs and ports. Clear byte_count and the overflow flag. Set drop = (s_udp_dest_port != LISTEN_PORT). Go to RECV.
  - RECV: s_udp_payload_axis_tready=1. On each beat:
    - if !drop && byte_count < MAX_PAYLOAD_BYTES, write tdata at address byte_count;
    - otherwise set overflow when !drop;
    - byte_count saturates at MAX_PAYLOAD_BYTES.
    On the tlast beat: if drop|overflow|tuser, increment frames_dropped and go to IDLE. Otherwise go to HDR_OUT on the next cycle.
  - HDR_OUT: m_udp_hdr_valid=1. All header fields are held stable until m_udp_hdr_ready. Issue buffer read of address 0 on entry. On handshake go to PAYLOAD_OUT.
  - PAYLOAD_OUT: m_udp_payload_axis_tvalid asserts the cycle after the header handshake. The output data register is prefetched, so there are no bubbles while tready=1. tdata, tvalid and tlast stay stable while tready=0. tlast=1 on byte index byte_count-1. On the tlast handshake, increment frames_echoed and go to IDLE. A new header may be accepted on the next cycle.
- Input tready is 0 outside its state. Input is backpressured during HDR_OUT and PAYLOAD_OUT, with single-frame buffering.
- m_udp_length comes from the counted bytes, not from any received length field.
- Latency: the echo header becomes valid 2 cycles after the input tlast handshake.
- Stray payload beats in IDLE are not accepted.

Decomposition:
- Package udp_echo_pkg holds:
  - state enum (IDLE, RECV, HDR_OUT, PAYLOAD_OUT);
  - UDP_HDR_BYTES=8;
  - default constants for DSCP, ECN and checksum.
- Sub-module udp_payload_buffer: simple dual-port RAM, depth MAX_PAYLOAD_BYTES, width 8, synchronous write, 1-cycle registered read, address width $clog2(MAX_PAYLOAD_BYTES).

Test Plan:
- Datagram 10.0.0.2:1234 -> 10.0.0.1:5000, payload 0x01..0x04, sink always ready -> header src 10.0.0.1:5000, dst 10.0.0.2:1234, length 12, ttl 64; payload 01,02,03,04 with tlast on 04; frames_echoed=1.
- Same datagram to port 5001 -> no m_udp_hdr_valid; frames_dropped=1; all 4 input beats accepted.
- 1-byte payload 0xAA with tuser=1 on tlast -> dropped, frames_dropped=1. Then 1-byte 0x55 valid -> echo length 9, single beat 0x55 with tlast.
- 1473-byte payload with MAX_PAYLOAD_BYTES=1472 -> dropped, no echo. A following 1472-byte frame echoes length 1480 with all bytes intact.
- Echo sink toggles tready every cycle on a 6-byte echo -> output bytes in order, stable while stalled; input tready=0 until echo tlast handshake.
- rst_n pulsed low during PAYLOAD_OUT after byte 2 -> all outputs 0 immediately, counters 0; next datagram echoes correctly.
